instr_decode_stage: RTL and testbench

//  Decode stage directly downstream of the program counter / fetch stage. Accepts the 32-bit fetched

---
 rtl/instr_pkg.sv | 50 +++++
 rtl/decode_skid_buf.sv | 42 ++++
 rtl/instr_decode_stage.sv | 90 +++++++++
 tb/tb_instr_decode_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// instr_pkg: instruction field positions, opcodes, ALU codes, decoded bundle and decode function
package instr_pkg;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB = 25;
  localparam int RD_LSB = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int FN_MSB = 3;
  localparam logic [5:0] OPC_ALU = 6'h01;
  localparam logic [5:0] OPC_ALUI = 6'h02;
  localparam logic [5:0] OPC_LOAD = 6'h03;
  localparam logic [5:0] OPC_STORE = 6'h04;
  localparam logic [5:0] OPC_BRANCH = 6'h05;
  localparam logic [5:0] OPC_HALT = 6'h08;
  localparam logic [3:0] ALU_NONE = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  typedef enum logic [1:0] {ST_RUN, ST_HALT_DRAIN, ST_HALTED} state_t;
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [31:0] imm;
    logic [3:0] alu_op;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic illegal;
  } dec_t;
  localparam int DEC_W = $bits(dec_t);
  // Register-register ALU ops take their function code from the low funct bits.
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    d.opcode = i[OPC_MSB:OPC_LSB];
    d.rd = i[RD_MSB:RD_LSB];
    d.rs1 = i[RS1_MSB:RS1_LSB];
    d.rs2 = i[RS2_MSB:RS2_LSB];
    d.imm = {{16{i[IMM_MSB]}}, i[IMM_MSB:0]};
    d.illegal = !(d.opcode inside {OPC_ALU, OPC_ALUI, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_HALT});
    d.alu_op = d.opcode == OPC_ALU ? i[FN_MSB:0] : d.opcode == OPC_ALUI ? ALU_ADD : ALU_NONE;
    d.is_load = d.opcode == OPC_LOAD;
    d.is_store = d.opcode == OPC_STORE;
    d.is_branch = d.opcode == OPC_BRANCH;
    return d;
  endfunction
endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf: generic 2-entry valid/ready skid buffer with registered in_ready
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);
  logic skid_v;
  logic [W-1:0] skid_d;
  logic in_fire;
  assign in_ready = !skid_v;
  assign in_fire = in_valid & in_ready;
  assign empty = !out_valid & !skid_v;
  // Skid only fills while the output register is stalled, so it is always older-than-input.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      skid_v <= 1'b0;
      out_data <= '0;
      skid_d <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_v) begin
        out_data <= skid_d;
        skid_v <= 1'b0;
        out_valid <= 1'b1;
      end else begin
        out_valid <= in_fire;
        if (in_fire) out_data <= in_data;
      end
    end else if (in_fire) begin
      skid_d <= in_data;
      skid_v <= 1'b1;
    end
  end
endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: decode stage with skid-buffered output and HALT FSM; DEC_PERF_CNT_EN adds perf counters
module instr_decode_stage
  import instr_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int INSTR_W = 32
`ifdef DEC_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               resume,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         out_opcode,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [31:0]        out_imm,
  output logic [3:0]         out_alu_op,
  output logic               out_is_load,
  output logic               out_is_store,
  output logic               out_is_branch,
  output logic               out_illegal,
  output logic               halted
`ifdef DEC_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_decoded
  , output logic [CNT_W-1:0] perf_illegal
`endif
);
  state_t state, state_n;
  dec_t d, ob;
  logic buf_ready, buf_empty, run, in_fire;
  logic [PC_W+DEC_W-1:0] buf_out;
  assign d = decode(in_instr);
  assign run = state == ST_RUN;
  assign in_ready = buf_ready & run;
  assign in_fire = in_valid & in_ready;
  assign halted = state == ST_HALTED;
  decode_skid_buf #(.W(PC_W + DEC_W)) u_buf (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid & run),
    .in_ready(buf_ready),
    .in_data({in_pc, d}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(buf_out),
    .empty(buf_empty)
  );
  assign {out_pc, ob} = buf_out;
  assign out_opcode = ob.opcode;
  assign out_rd = ob.rd;
  assign out_rs1 = ob.rs1;
  assign out_rs2 = ob.rs2;
  assign out_imm = ob.imm;
  assign out_alu_op = ob.alu_op;
  assign out_is_load = ob.is_load;
  assign out_is_store = ob.is_store;
  assign out_is_branch = ob.is_branch;
  assign out_illegal = ob.illegal;
  always_ff @(posedge clk) begin
    state <= reset ? ST_RUN : state_n;
  end
  always_comb begin
    state_n = state;
    state_n = (run && in_fire && d.opcode == OPC_HALT) ? ST_HALT_DRAIN :
              (state == ST_HALT_DRAIN && buf_empty) ? ST_HALTED :
              (halted && resume) ? ST_RUN : state;
  end
`ifdef DEC_PERF_CNT_EN
  logic out_fire;
  assign out_fire = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
    end else if (out_fire) begin
      perf_decoded <= perf_decoded + {{(CNT_W-1){1'b0}}, ~&perf_decoded};
      perf_illegal <= perf_illegal + {{(CNT_W-1){1'b0}}, out_illegal & ~&perf_illegal};
    end
  end
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed spec scenarios plus randomized traffic against a transaction-level model
module tb_instr_decode_stage;
  logic clk = 0, reset = 1, in_valid = 0, resume = 0, out_ready = 0;
  logic in_ready, out_valid, halted, ld, st, br, ill;
  logic [31:0] in_instr = 0, imm;
  logic [7:0] in_pc = 0, out_pc;
  logic [5:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [3:0] alu;
`ifdef DEC_PERF_CNT_EN
  logic [15:0] perf_decoded, perf_illegal;
`endif
  int errors = 0, checks = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  instr_decode_stage dut (
`ifdef DEC_PERF_CNT_EN
    .perf_decoded(perf_decoded), .perf_illegal(perf_illegal),
`endif
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .resume(resume), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(opc), .out_rd(rd), .out_rs1(rs1), .out_rs2(rs2), .out_imm(imm), .out_alu_op(alu),
    .out_is_load(ld), .out_is_store(st), .out_is_branch(br), .out_illegal(ill), .halted(halted)
  );

  typedef struct {
    logic [7:0] pc; logic [5:0] opc; logic [4:0] rd, rs1, rs2; logic [31:0] imm;
    logic [3:0] alu; logic ld, st, br, ill;
  } exp_t;
  exp_t q[$];
  int mode = 0;
  int unsigned m_dec = 0, m_ill = 0;
  bit m_rdy, m_acc, m_fire;
  int m_next;

  function automatic exp_t model(logic [31:0] i, logic [7:0] pc);
    exp_t e;
    e.pc = pc; e.opc = i[31:26]; e.rd = i[25:21]; e.rs1 = i[20:16]; e.rs2 = i[15:11];
    e.imm = i[15] ? (32'hFFFF_0000 | {16'h0, i[15:0]}) : {16'h0, i[15:0]};
    e.alu = 0; e.ld = 0; e.st = 0; e.br = 0; e.ill = 0;
    case (e.opc)
      6'h01: e.alu = i[3:0];
      6'h02: e.alu = 4'h1;
      6'h03: e.ld = 1;
      6'h04: e.st = 1;
      6'h05: e.br = 1;
      6'h08: ;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2 && mode == 0);
      chk("halted", halted, mode == 2);
      if (q.size() > 0) begin
        chk("pc", out_pc, q[0].pc); chk("opcode", opc, q[0].opc);
        chk("rd", rd, q[0].rd); chk("rs1", rs1, q[0].rs1); chk("rs2", rs2, q[0].rs2);
        chk("imm", imm, q[0].imm); chk("alu_op", alu, q[0].alu);
        chk("flags", {ld, st, br, ill}, {q[0].ld, q[0].st, q[0].br, q[0].ill});
      end
`ifdef DEC_PERF_CNT_EN
      chk("perf_decoded", perf_decoded, m_dec);
      chk("perf_illegal", perf_illegal, m_ill);
`endif
    end
    if (reset) begin
      q.delete(); mode = 0; m_dec = 0; m_ill = 0;
    end else begin
      m_rdy = q.size() < 2 && mode == 0;
      m_acc = in_valid && m_rdy;
      m_fire = q.size() > 0 && out_ready;
      m_next = mode;
      if (mode == 0 && m_acc && in_instr[31:26] == 6'h08) m_next = 1;
      if (mode == 1 && q.size() == 0) m_next = 2;
      if (mode == 2 && resume) m_next = 0;
      if (m_fire) begin
        if (m_dec != 32'hFFFF) m_dec++;
        if (q[0].ill && m_ill != 32'hFFFF) m_ill++;
        void'(q.pop_front());
      end
      if (m_acc) q.push_back(model(in_instr, in_pc));
      mode = m_next;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(bit v, logic [31:0] i, logic [7:0] pc);
    in_valid = v; in_instr = i; in_pc = pc;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 15);
    r[31:26] = k < 3 ? 6'h01 : k < 5 ? 6'h02 : k < 7 ? 6'h03 : k < 9 ? 6'h04 :
               k < 11 ? 6'h05 : k == 11 ? 6'h08 : k == 12 ? 6'h3F : 6'($urandom);
    return r;
  endfunction

  initial begin
    out_ready = 1;
    step(); chk_en = 1; step();
    @(negedge clk);
    chk("rst out_valid", out_valid, 0); chk("rst in_ready", in_ready, 1);
    chk("rst halted", halted, 0); chk("rst out_pc", out_pc, 0); chk("rst imm", imm, 0);
    step(); reset = 0;
    drive(1, 32'h0443_0800, 8'h05); step(); drive(0, 0, 0);
    @(negedge clk);
    chk("t1 valid", out_valid, 1); chk("t1 rd", rd, 2); chk("t1 rs1", rs1, 3);
    chk("t1 rs2", rs2, 1); chk("t1 pc", out_pc, 8'h05);
    step(); drive(1, {6'h03, 5'd1, 5'd2, 16'hFFF0}, 8'h06); step(); drive(0, 0, 0);
    @(negedge clk);
    chk("t2 imm", imm, 32'hFFFF_FFF0); chk("t2 flags", {ld, st, br, ill}, 4'b1000);
    step(); drive(1, {6'h3F, 26'h123_4567}, 8'h07); step(); drive(0, 0, 0);
    @(negedge clk);
    chk("t4 flags", {ld, st, br, ill}, 4'b0001); chk("t4 alu", alu, 0);
    step();
`ifdef DEC_PERF_CNT_EN
    @(negedge clk);
    chk("t4 perf_illegal", perf_illegal, 1); chk("t4 perf_decoded", perf_decoded, 3);
`endif
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, {6'h01, 5'(k), 21'h0}, 8'h10 + 8'(k)); step();
    end
    drive(0, 0, 0);
    @(negedge clk);
    chk("t3 in_ready", in_ready, 0); chk("t3 head pc", out_pc, 8'h10);
    out_ready = 1; step();
    @(negedge clk); chk("t3 second pc", out_pc, 8'h11);
    step(); @(negedge clk); chk("t3 drained", out_valid, 0);
    drive(1, {6'h08, 26'h0}, 8'h20); step();
    drive(1, {6'h01, 26'h0}, 8'h21);
    for (int k = 0; k < 10 && !halted; k++) step();
    @(negedge clk);
    chk("t5 halted", halted, 1); chk("t5 in_ready", in_ready, 0); chk("t5 empty", out_valid, 0);
    step(); resume = 1; step(); resume = 0;
    @(negedge clk); chk("t5 resumed", in_ready, 1);
    step(); drive(0, 0, 0);
    @(negedge clk); chk("t5 add out", out_valid, 1); chk("t5 add pc", out_pc, 8'h21);
    out_ready = 0;
    drive(1, {6'h3F, 26'h0}, 8'h30); step(); step(); drive(0, 0, 0); step();
    @(negedge clk); chk("t6 full", in_ready, 0);
    reset = 1; step(); reset = 0;
    @(negedge clk);
    chk("t6 out_valid", out_valid, 0); chk("t6 in_ready", in_ready, 1);
`ifdef DEC_PERF_CNT_EN
    chk("t6 perf", {perf_decoded, perf_illegal}, 0);
`endif
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, rnd_instr(), 8'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      resume = $urandom_range(0, 9) == 0;
      reset = $urandom_range(0, 399) == 0;
      step();
    end
    reset = 0; drive(0, 0, 0); resume = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
